pong_engine: RTL and testbench
==============================

# pong_engine

Parametrised paddle-and-ball game engine that owns gameplay state and renders it into the pixel framebuffer through a single arbitrated write port. Successor of the fixed 160x128 game FSM: configurable screen/paddle geometry and speed, one shared write port with back-pressure, tick-based motion, score and lives. Sits between the button synchronisers and the framebuffer write arbiter, alongside the VGA scan-out.

## Interface
- AW, 15, framebuffer address width
- DW, 3, pixel colour width
- SCR_W, 160, screen width in pixels
- SCR_H, 128, screen height in pixels
- PAD_Y, 96, paddle row
- PAD_W, 6, paddle width in pixels
- TICK_DIV, 50000, clk cycles per motion tick (≥ 32)
- LIVES, 3, lives per game (1..7)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- btn_l, btn_r, btn_start  in  1 each  synchronised, level buttons
- px_ready  in  1  arbiter accepts write this cycle
- px_wr  out  1  write request
- px_addr  out  AW  y*SCR_W + x
- px_data  out  DW  pixel colour
- score  out  8  paddle hits, saturating at 255
- lives  out  3  remaining lives
- game_over  out  1  high in OVER

## Operation
- Colours: BG=3'b001, PAD=3'b010, BALL=3'b111, RED=3'b100.
- States: CLEAR → IDLE → PLAY → (MISS → PLAY | OVER); OVER + btn_start → CLEAR.
- CLEAR: writes BG to every address 0..SCR_W*SCR_H-1 ascending, then IDLE. Loads lives=LIVES, score=0, pad_x=(SCR_W-PAD_W)/2, ball=(SCR_W/2, SCR_H/2), dx=+1, dy=-1.
- IDLE: draws paddle and ball once; btn_start → PLAY.
- PLAY, per tick: paddle: btn_l only → pad_x-1 if >1; btn_r only → pad_x+1 if < SCR_W-1-PAD_W; both/neither → hold.
- Ball x: if x+dx outside [1, SCR_W-2], dx negated and x held this tick; else x+=dx. Same for y with top bound 1.
- Ball at y=PAD_Y-1 with dy=+1: hit if pad_x-1 ≤ x ≤ pad_x+PAD_W → dy=-1, y held, score+1 (saturating); else MISS.
- Draw sequence after each update: BG at old ball, BALL at new ball, BG at pad_x-1, PAD at pad_x..pad_x+PAD_W-1, BG at pad_x+PAD_W (PAD_W+4 writes).
- MISS: lives-1; BG at old ball; if lives now 0 → OVER, else ball re-served at centre, dy=-1, dx kept, PLAY.
- OVER: writes RED to (SCR_W/2, SCR_H/2), then idles with game_over=1.

## Timing
- Reset: px_wr=0, px_addr=0, px_data=0, score=0, lives=0, game_over=0, state CLEAR (CLEAR begins first cycle after rst drops). rst mid-sequence aborts writes immediately.
- Write handshake: a write commits in a cycle with px_wr && px_ready. While px_wr && !px_ready, addr/data/wr held stable. Back-to-back writes allowed (1/cycle at full ready).
- Tick counter runs only in PLAY; tick during an active draw sets one pending flag, further ticks dropped; pending tick processed the cycle after the draw ends.
- Buttons sampled on the tick cycle only.
- Address: x, y widths $clog2(SCR_W), $clog2(SCR_H); product computed at AW bits, no truncation for legal parameters (SCR_W*SCR_H ≤ 2^AW, checked at elaboration).
- score/lives update in the same cycle the state transition is decided.

## Structure
- pong_pkg: colour constants, state enum, button/tick typedefs.
- One sub-module: px_writer — small queue-free sequencer taking (addr, data, valid) from the FSM with ready back-pressure, owning px_wr/px_addr/px_data hold logic.
- Tick divider and collision logic stay in pong_engine.

## Test plan
- Reset, px_ready=1, SCR_W=16,SCR_H=8 → exactly 128 BG writes to 0..127, then IDLE draw; px_wr never asserted during rst.
- px_ready toggling 50% random during CLEAR → every address written once, addr/data stable across stalls.
- PLAY, btn_l held, pad_x at 1 → pad_x stays 1, redraw still issued each tick; both buttons → no move.
- Ball at (SCR_W-2, 10), dx=+1 → dx=-1, x=SCR_W-2 that tick, x=SCR_W-3 next tick.
- Ball at y=PAD_Y-1, x=pad_x+PAD_W, dy=+1 → hit, score 0→1; x=pad_x+PAD_W+1 → MISS, lives 3→2, ball at centre.
- Three misses → game_over=1, RED at centre address; btn_start → CLEAR restarts, score=0, lives=LIVES.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared definitions for the pong engine: pixel colours, game states and
// the small typedefs used between the tick logic and the draw sequencer.
package pong_pkg;

  localparam logic [2:0] C_BG   = 3'b001;
  localparam logic [2:0] C_PAD  = 3'b010;
  localparam logic [2:0] C_BALL = 3'b111;
  localparam logic [2:0] C_RED  = 3'b100;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_PLAY,
    S_MISS,
    S_OVER
  } state_t;

  typedef struct packed {
    logic l;
    logic r;
  } btn_t;

  typedef logic tick_t;

endpackage

// File: rtl/pong_engine_px_writer.sv
// Single-entry write stage towards the framebuffer arbiter: holds
// px_wr/px_addr/px_data steady while the arbiter stalls.
module px_writer #(
  parameter int AW = 15,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic          req_ready,
  input  logic          px_ready,
  output logic          px_wr,
  output logic [AW-1:0] px_addr,
  output logic [DW-1:0] px_data
);

  // The slot frees up when empty or when the held write commits this cycle.
  assign req_ready = !px_wr || px_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      px_wr   <= 1'b0;
      px_addr <= '0;
      px_data <= '0;
    end else if (req_ready) begin
      px_wr <= req_valid;
      if (req_valid) begin
        px_addr <= req_addr;
        px_data <= req_data;
      end
    end
  end

endmodule

// File: rtl/pong_engine.sv
// Paddle-and-ball game engine: game state, tick-based motion, collisions,
// score/lives, and pixel draw sequences issued through px_writer.
module pong_engine
  import pong_pkg::*;
#(
  parameter int AW       = 15,
  parameter int DW       = 3,
  parameter int SCR_W    = 160,
  parameter int SCR_H    = 128,
  parameter int PAD_Y    = 96,
  parameter int PAD_W    = 6,
  parameter int TICK_DIV = 50000,
  parameter int LIVES    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_l,
  input  logic          btn_r,
  input  logic          btn_start,
  input  logic          px_ready,
  output logic          px_wr,
  output logic [AW-1:0] px_addr,
  output logic [DW-1:0] px_data,
  output logic [7:0]    score,
  output logic [2:0]    lives,
  output logic          game_over
);

  // One spare bit on coordinates so x-1 / x+1 never wrap in comparisons.
  localparam int XW = $clog2(SCR_W) + 1;
  localparam int YW = $clog2(SCR_H) + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(PAD_W + 4);

  localparam logic [AW-1:0] PIX_LAST  = AW'(SCR_W * SCR_H - 1);
  localparam logic [XW-1:0] X_ONE     = XW'(1);
  localparam logic [XW-1:0] X_MID     = XW'(SCR_W / 2);
  localparam logic [XW-1:0] X_HI      = XW'(SCR_W - 2);
  localparam logic [XW-1:0] PAD_HI    = XW'(SCR_W - 1 - PAD_W);
  localparam logic [XW-1:0] PAD_INIT  = XW'((SCR_W - PAD_W) / 2);
  localparam logic [XW-1:0] PAD_WX    = XW'(PAD_W);
  localparam logic [YW-1:0] Y_ONE     = YW'(1);
  localparam logic [YW-1:0] Y_MID     = YW'(SCR_H / 2);
  localparam logic [YW-1:0] Y_HI      = YW'(SCR_H - 2);
  localparam logic [YW-1:0] Y_PAD     = YW'(PAD_Y);
  localparam logic [YW-1:0] Y_HIT     = YW'(PAD_Y - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(PAD_W + 3);

  if ((SCR_W * SCR_H > (1 << AW)) || (TICK_DIV < 32) || (LIVES < 1) || (LIVES > 7))
  begin : g_bad_params
    $error("pong_engine: illegal parameter combination");
  end

  function automatic logic [AW-1:0] pix(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return AW'(y) * AW'(SCR_W) + AW'(x);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t        state;
  logic          busy;
  logic [SW-1:0] step;
  logic [AW-1:0] clr_addr;
  logic [TW-1:0] tick_cnt;
  logic          tick_pend;
  btn_t          btn_lat;
  logic [XW-1:0] pad_x, bx, ob_x;
  logic [YW-1:0] by, ob_y;
  logic          dx_neg, dy_neg;

  tick_t         tick;
  btn_t          btn_use;
  logic [XW-1:0] pad_nxt;
  logic          at_row, hit, miss, x_wall, y_wall;

  logic          req_valid, req_ready, accept;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;

  assign tick   = (state == S_PLAY) && (tick_cnt == TICK_LAST);
  assign accept = req_valid && req_ready;

  always_comb begin
    btn_use = tick ? btn_t'({btn_l, btn_r}) : btn_lat;
    pad_nxt = pad_x;
    if (btn_use.l && !btn_use.r && pad_x > X_ONE)
      pad_nxt = pad_x - X_ONE;
    else if (btn_use.r && !btn_use.l && pad_x < PAD_HI)
      pad_nxt = pad_x + X_ONE;
    // Hit window spans one pixel either side of the (already moved) paddle.
    at_row = (by == Y_HIT) && !dy_neg;
    hit    = at_row && (bx + X_ONE >= pad_nxt) && (bx <= pad_nxt + PAD_WX);
    miss   = at_row && !hit;
    x_wall = dx_neg ? (bx <= X_ONE) : (bx >= X_HI);
    y_wall = dy_neg ? (by <= Y_ONE) : (by >= Y_HI);
  end

  // Draw order: erase old ball, ball, left erase, paddle body, right erase.
  always_comb begin
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = DW'(C_BG);
    case (state)
      S_CLEAR: begin
        req_valid = 1'b1;
        req_addr  = clr_addr;
      end
      S_IDLE, S_PLAY: begin
        req_valid = busy;
        if (step == '0) begin
          req_addr = pix(ob_x, ob_y);
        end else if (step == SW'(1)) begin
          req_addr = pix(bx, by);
          req_data = DW'(C_BALL);
        end else begin
          req_addr = pix(pad_x + XW'(step) - XW'(3), Y_PAD);
          if (step != SW'(2) && step != STEP_LAST)
            req_data = DW'(C_PAD);
        end
      end
      S_MISS: begin
        req_valid = 1'b1;
        req_addr  = pix(ob_x, ob_y);
      end
      S_OVER: begin
        req_valid = busy;
        req_addr  = pix(X_MID, Y_MID);
        req_data  = DW'(C_RED);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLEAR;
      busy      <= 1'b0;
      step      <= '0;
      clr_addr  <= '0;
      tick_cnt  <= '0;
      tick_pend <= 1'b0;
      score     <= '0;
      lives     <= '0;
      game_over <= 1'b0;
    end else begin
      tick_cnt <= (state != S_PLAY || tick) ? '0 : tick_cnt + TW'(1);
      case (state)
        S_CLEAR: if (accept) begin
          if (clr_addr == PIX_LAST) begin
            state  <= S_IDLE;
            busy   <= 1'b1;
            step   <= '0;
            score  <= '0;
            lives  <= 3'(LIVES);
            pad_x  <= PAD_INIT;
            bx     <= X_MID;
            by     <= Y_MID;
            ob_x   <= X_MID;
            ob_y   <= Y_MID;
            dx_neg <= 1'b0;
            dy_neg <= 1'b1;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        S_IDLE: begin
          if (busy) begin
            if (accept) begin
              busy <= (step != STEP_LAST);
              step <= step + SW'(1);
            end
          end else if (btn_start) begin
            state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (busy) begin
            if (accept) begin
              busy <= (step != STEP_LAST);
              step <= step + SW'(1);
            end
            // Only the first tick during a draw is remembered, with its buttons.
            if (tick && !tick_pend) begin
              tick_pend <= 1'b1;
              btn_lat   <= btn_t'({btn_l, btn_r});
            end
          end else if (tick || tick_pend) begin
            tick_pend <= 1'b0;
            pad_x     <= pad_nxt;
            ob_x      <= bx;
            ob_y      <= by;
            if (miss) begin
              state <= S_MISS;
              lives <= lives - 3'd1;
            end else begin
              busy <= 1'b1;
              step <= '0;
              if (hit) begin
                dy_neg <= 1'b1;
                score  <= sat_inc(score);
              end else if (y_wall) begin
                dy_neg <= ~dy_neg;
              end else begin
                by <= dy_neg ? by - Y_ONE : by + Y_ONE;
              end
              if (x_wall) dx_neg <= ~dx_neg;
              else        bx <= dx_neg ? bx - X_ONE : bx + X_ONE;
            end
          end
        end
        S_MISS: if (accept) begin
          if (lives == '0) begin
            state     <= S_OVER;
            game_over <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state  <= S_PLAY;
            bx     <= X_MID;
            by     <= Y_MID;
            dy_neg <= 1'b1;
          end
        end
        S_OVER: begin
          if (busy) begin
            if (accept) busy <= 1'b0;
          end else if (btn_start) begin
            state     <= S_CLEAR;
            clr_addr  <= '0;
            game_over <= 1'b0;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  px_writer #(.AW(AW), .DW(DW)) u_px_writer (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .px_ready  (px_ready),
    .px_wr     (px_wr),
    .px_addr   (px_addr),
    .px_data   (px_data)
  );

endmodule

// File: tb/tb_pong_engine.sv
// Scoreboard bench for pong_engine on a 16x8 screen: a behavioural game model
// queues the expected pixel writes per tick and the monitor checks each commit.
module tb_pong_engine;

  localparam int AW = 7, DW = 3, W = 16, H = 8, PY = 6, PW = 4, TD = 32, NL = 3;
  localparam int BG = 1, PAD = 2, BALL = 7, RED = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          btn_l = 1'b0, btn_r = 1'b0, btn_start = 1'b0, px_ready = 1'b1;
  logic          px_wr, game_over;
  logic [AW-1:0] px_addr;
  logic [DW-1:0] px_data;
  logic [7:0]    score;
  logic [2:0]    lives;

  pong_engine #(.AW(AW), .DW(DW), .SCR_W(W), .SCR_H(H), .PAD_Y(PY), .PAD_W(PW),
                .TICK_DIV(TD), .LIVES(NL)) dut (
    .clk(clk), .rst(rst), .btn_l(btn_l), .btn_r(btn_r), .btn_start(btn_start),
    .px_ready(px_ready), .px_wr(px_wr), .px_addr(px_addr), .px_data(px_data),
    .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int       n_checks = 0, n_errors = 0;
  int       exp_q[$];
  bit       rand_rdy = 1'b1;
  bit       stall = 1'b0;
  int       held = 0;
  int       m_pad, m_bx, m_by, m_dx, m_dy, m_score, m_lives;
  bit       m_over;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  function automatic int pix(input int x, input int y);
    return y * W + x;
  endfunction

  function automatic int wr(input int x, input int y, input int c);
    return (pix(x, y) << DW) | c;
  endfunction

  task automatic push_draw(input int ox, input int oy);
    exp_q.push_back(wr(ox, oy, BG));
    exp_q.push_back(wr(m_bx, m_by, BALL));
    exp_q.push_back(wr(m_pad - 1, PY, BG));
    for (int i = 0; i < PW; i++) exp_q.push_back(wr(m_pad + i, PY, PAD));
    exp_q.push_back(wr(m_pad + PW, PY, BG));
  endtask

  task automatic model_new_game();
    for (int a = 0; a < W * H; a++) exp_q.push_back((a << DW) | BG);
    m_pad = (W - PW) / 2; m_bx = W / 2; m_by = H / 2; m_dx = 1; m_dy = -1;
    m_score = 0; m_lives = NL; m_over = 1'b0;
    push_draw(m_bx, m_by);
  endtask

  task automatic model_tick(input bit l, input bit r);
    int ox, oy;
    bit lost;
    ox = m_bx; oy = m_by; lost = 1'b0;
    if (l && !r && m_pad > 1) m_pad--;
    else if (r && !l && m_pad < W - 1 - PW) m_pad++;
    if (m_by == PY - 1 && m_dy == 1) begin
      if (m_bx >= m_pad - 1 && m_bx <= m_pad + PW) begin
        m_dy = -1;
        if (m_score < 255) m_score++;
      end else lost = 1'b1;
    end else if (m_by + m_dy < 1 || m_by + m_dy > H - 2) m_dy = -m_dy;
    else m_by += m_dy;
    if (lost) begin
      exp_q.push_back(wr(ox, oy, BG));
      m_lives--;
      if (m_lives == 0) begin
        exp_q.push_back(wr(W / 2, H / 2, RED));
        m_over = 1'b1;
      end else begin
        m_bx = W / 2; m_by = H / 2; m_dy = -1;
      end
    end else begin
      if (m_bx + m_dx < 1 || m_bx + m_dx > W - 2) m_dx = -m_dx;
      else m_bx += m_dx;
      push_draw(ox, oy);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", 32'(exp_q.size()), 0);
  endtask

  task automatic play_tick(input bit l, input bit r);
    btn_l = l; btn_r = r;
    model_tick(l, r);
    drain(300);
    check("score", 32'(score), 32'(m_score));
    check("lives", 32'(lives), 32'(m_lives));
    check("game_over", 32'(game_over), 32'(m_over));
  endtask

  initial forever begin
    @(posedge clk); #1;
    px_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      check("wr_in_rst", 32'(px_wr), 0);
      stall = 1'b0;
    end else begin
      if (stall) check("hold", 32'({px_wr, px_addr, px_data}), 32'((1 << (AW + DW)) | held));
      if (px_wr && px_ready) begin
        check("wr_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("wr", 32'({px_addr, px_data}), 32'(exp_q.pop_front()));
      end
      stall = px_wr && !px_ready;
      held  = int'({px_addr, px_data});
    end
  end

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check("rst_wr", 32'(px_wr), 0);
    check("rst_addr", 32'(px_addr), 0);
    check("rst_data", 32'(px_data), 0);
    check("rst_score", 32'(score), 0);
    check("rst_lives", 32'(lives), 0);
    check("rst_over", 32'(game_over), 0);

    model_new_game();
    rst = 1'b0;
    drain(3000);
    rand_rdy = 1'b0;
    check("idle_lives", 32'(lives), NL);
    check("idle_score", 32'(score), 0);

    btn_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      play_tick(1'b1, 1'b0);
      btn_start = 1'b0;
    end
    check("pad_clamp_left", 32'(m_pad), 1);
    for (int i = 0; i < 3; i++) play_tick(1'b1, 1'b1);

    for (int i = 0; i < 150 && m_score < 2 && !m_over; i++)
      play_tick(m_pad + PW / 2 > m_bx, m_pad + PW / 2 < m_bx);

    for (int i = 0; i < 400 && !m_over; i++)
      play_tick(m_bx >= W / 2, m_bx < W / 2);
    check("final_over", 32'(game_over), 1);
    check("final_lives", 32'(lives), 0);

    model_new_game();
    btn_start = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    btn_start = 1'b0;
    drain(3000);
    check("restart_score", 32'(score), 0);
    check("restart_lives", 32'(lives), NL);
    check("restart_over", 32'(game_over), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
